// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: parses 'W' addr data / 'R' addr host frames from uart_rx, runs them
// on an 8-bit register bank and returns one reply byte through uart_tx.
// Optional inter-byte timeout in GET_ADDR/GET_DATA: define UART_CMD_TIMEOUT_EN.
module uart_cmd_ctrl #(
    parameter int NUM_REGS     = 8,
    parameter int ADDR_W       = 3,
    parameter int TIMEOUT_CLKS = 1420
) (
    input  logic                  clk_in,
    input  logic                  rst_in_n,
    input  logic                  rx_dv_in,
    input  logic [7:0]            rx_data_in,
    output logic                  tx_dv_out,
    output logic [7:0]            tx_data_out,
    input  logic                  tx_active_in,
    input  logic                  tx_done_in,
    output logic [NUM_REGS*8-1:0] regs_out,
    output logic                  wr_strobe_out,
    output logic [ADDR_W-1:0]     wr_addr_out,
    output logic                  busy_out,
    output logic                  overrun_out
);
    localparam logic [7:0] CMD_WR = 8'h57;
    localparam logic [7:0] CMD_RD = 8'h52;
    localparam logic [7:0] ACK    = 8'h06;
    localparam logic [7:0] NAK    = 8'h15;

    typedef enum logic [2:0] {
        IDLE, GET_ADDR, GET_DATA, EXEC, SEND, WAIT_DONE
    } state_t;

    state_t state, state_nxt;

    logic              is_wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic              in_range_q;
    logic [7:0]        data_q;
    logic [7:0]        reply_q;
    logic [ADDR_W-1:0] last_wr_addr_q;
    logic [7:0]        regs_q [NUM_REGS];
    logic [7:0]        rd_data;
    logic              timeout;

    // The whole address byte is range-checked, so high bits cannot alias onto a register.
    function automatic logic addr_in_range(input logic [7:0] a);
        return {1'b0, a} < 9'(NUM_REGS);
    endfunction

`ifdef UART_CMD_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CLKS + 1);
    logic [TO_W-1:0] to_cnt_q;

    always_ff @(posedge clk_in) begin
        if (!rst_in_n || rx_dv_in || !(state == GET_ADDR || state == GET_DATA))
            to_cnt_q <= '0;
        else
            to_cnt_q <= to_cnt_q + 1'b1;
    end

    assign timeout = (to_cnt_q == TO_W'(TIMEOUT_CLKS - 1));
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        rd_data = 8'h00;
        for (int k = 0; k < NUM_REGS; k++)
            if (addr_q == ADDR_W'(k)) rd_data = regs_q[k];
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in_n) state <= IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        tx_dv_out     = 1'b0;
        wr_strobe_out = 1'b0;
        overrun_out   = 1'b0;
        case (state)
            IDLE: begin
                if (rx_dv_in)
                    state_nxt = (rx_data_in == CMD_WR || rx_data_in == CMD_RD) ? GET_ADDR : SEND;
            end
            GET_ADDR: begin
                if (rx_dv_in)     state_nxt = is_wr_q ? GET_DATA : EXEC;
                else if (timeout) state_nxt = IDLE;
            end
            GET_DATA: begin
                if (rx_dv_in)     state_nxt = EXEC;
                else if (timeout) state_nxt = IDLE;
            end
            EXEC: begin
                wr_strobe_out = is_wr_q && in_range_q;
                overrun_out   = rx_dv_in;
                state_nxt     = SEND;
            end
            SEND: begin
                overrun_out = rx_dv_in;
                if (!tx_active_in) begin
                    tx_dv_out = 1'b1;
                    state_nxt = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                overrun_out = rx_dv_in;
                if (tx_done_in) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Frame capture and execution; reply_q is only rewritten in IDLE/EXEC so it
    // stays stable for uart_tx from the tx_dv_out cycle until tx_done_in.
    always_ff @(posedge clk_in) begin
        if (!rst_in_n) begin
            is_wr_q        <= 1'b0;
            addr_q         <= '0;
            in_range_q     <= 1'b0;
            data_q         <= 8'h00;
            reply_q        <= 8'h00;
            last_wr_addr_q <= '0;
            for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= 8'h00;
        end else begin
            if (state == IDLE && rx_dv_in) begin
                is_wr_q <= (rx_data_in == CMD_WR);
                if (rx_data_in != CMD_WR && rx_data_in != CMD_RD) reply_q <= NAK;
            end
            if (state == GET_ADDR && rx_dv_in) begin
                addr_q     <= rx_data_in[ADDR_W-1:0];
                in_range_q <= addr_in_range(rx_data_in);
            end
            if (state == GET_DATA && rx_dv_in) data_q <= rx_data_in;
            if (state == EXEC) begin
                reply_q <= !in_range_q ? NAK : (is_wr_q ? ACK : rd_data);
                if (wr_strobe_out) begin
                    last_wr_addr_q <= addr_q;
                    for (int k = 0; k < NUM_REGS; k++)
                        if (addr_q == ADDR_W'(k)) regs_q[k] <= data_q;
                end
            end
        end
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
        assign regs_out[8*k +: 8] = regs_q[k];
    end

    assign tx_data_out = reply_q;
    assign wr_addr_out = wr_strobe_out ? addr_q : last_wr_addr_q;
    assign busy_out    = (state != IDLE);

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Bench for uart_cmd_ctrl: table of host frames checked through a reply/write
// scoreboard against a small uart_tx responder, plus hand sequences for corner cases.
module tb_uart_cmd_ctrl;
    localparam int NUM_REGS     = 6;
    localparam int ADDR_W       = 3;
    localparam int TIMEOUT_CLKS = 1420;
    localparam int NV           = 14;

    logic                  clk_in     = 1'b0;
    logic                  rst_in_n   = 1'b0;
    logic                  rx_dv_in   = 1'b0;
    logic [7:0]            rx_data_in = 8'h00;
    logic                  tx_dv_out;
    logic [7:0]            tx_data_out;
    logic                  tx_active_in;
    logic                  tx_done_in;
    logic [NUM_REGS*8-1:0] regs_out;
    logic                  wr_strobe_out;
    logic [ADDR_W-1:0]     wr_addr_out;
    logic                  busy_out;
    logic                  overrun_out;

    logic model_busy = 1'b0;
    logic model_done = 1'b0;
    logic hold_busy  = 1'b0;
    logic man_done   = 1'b0;
    logic manual_tx  = 1'b0;
    int   tx_seen    = 0;
    int   tx_taken   = 0;
    int   tx_cnt     = 0;
    int   ovr_cnt    = 0;
    logic [7:0] last_tx = 8'h00;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]        exp_regs [NUM_REGS];
    logic [7:0]        reply_q  [$];
    logic [ADDR_W-1:0] wr_q     [$];

    typedef struct {
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        int         nb;
        logic [7:0] reply;
        logic       wr;
    } vec_t;
    vec_t vecs [NV];

    assign tx_active_in = model_busy | hold_busy;
    assign tx_done_in   = model_done | man_done;

    always #5 clk_in = ~clk_in;

    uart_cmd_ctrl #(
        .NUM_REGS    (NUM_REGS),
        .ADDR_W      (ADDR_W),
        .TIMEOUT_CLKS(TIMEOUT_CLKS)
    ) dut (
        .clk_in       (clk_in),
        .rst_in_n     (rst_in_n),
        .rx_dv_in     (rx_dv_in),
        .rx_data_in   (rx_data_in),
        .tx_dv_out    (tx_dv_out),
        .tx_data_out  (tx_data_out),
        .tx_active_in (tx_active_in),
        .tx_done_in   (tx_done_in),
        .regs_out     (regs_out),
        .wr_strobe_out(wr_strobe_out),
        .wr_addr_out  (wr_addr_out),
        .busy_out     (busy_out),
        .overrun_out  (overrun_out)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data_in = b;
        rx_dv_in   = 1'b1;
        tick();
        rx_dv_in   = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int cycles = 0;
        while ((busy_out || reply_q.size() != 0) && cycles < 200) begin
            tick();
            cycles++;
        end
        check(name, 64'(cycles < 200), 64'd1);
    endtask

    task automatic wait_tx_start(input int base);
        int cycles = 0;
        while (tx_seen == base && cycles < 50) begin
            tick();
            cycles++;
        end
        check("tx_start", 64'(tx_seen - base), 64'd1);
    endtask

    task automatic check_regs(input string name);
        logic [NUM_REGS*8-1:0] exp;
        for (int k = 0; k < NUM_REGS; k++) exp[8*k +: 8] = exp_regs[k];
        check(name, 64'(regs_out), 64'(exp));
    endtask

    task automatic pulse_reset();
        rst_in_n = 1'b0;
        tick();
        rst_in_n = 1'b1;
        for (int k = 0; k < NUM_REGS; k++) exp_regs[k] = 8'h00;
    endtask

    // Scoreboard side: every reply byte and register write is matched in order.
    always @(negedge clk_in) begin
        if (tx_dv_out) begin
            tx_seen++;
            last_tx = tx_data_out;
            check("tx_dv_while_active", 64'(tx_active_in), 64'd0);
            if (reply_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_tx: got 0x%0h, expected no transmission", tx_data_out);
            end else begin
                check("tx_reply", 64'(tx_data_out), 64'(reply_q.pop_front()));
            end
        end
        if (wr_strobe_out) begin
            if (wr_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_wr: got strobe addr %0d, expected no write", wr_addr_out);
            end else begin
                check("wr_addr", 64'(wr_addr_out), 64'(wr_q.pop_front()));
            end
        end
        if (tx_done_in && busy_out) check("tx_data_hold", 64'(tx_data_out), 64'(last_tx));
        if (overrun_out) ovr_cnt++;
    end

    // uart_tx responder: busy for 4 cycles after each start, then a done strobe.
    always @(posedge clk_in) begin
        #1;
        model_done = 1'b0;
        if (tx_seen != tx_taken) begin
            tx_taken = tx_seen;
            if (!manual_tx) begin
                model_busy = 1'b1;
                tx_cnt     = 4;
            end
        end else if (tx_cnt > 0) begin
            tx_cnt--;
            if (tx_cnt == 0) begin
                model_busy = 1'b0;
                model_done = 1'b1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, expected $finish earlier");
        $fatal(1);
    end

    initial begin
        int base;
        int ovr_base;

        vecs[0]  = '{8'h57, 8'h02, 8'hA5, 3, 8'h06, 1'b1};
        vecs[1]  = '{8'h52, 8'h02, 8'h00, 2, 8'hA5, 1'b0};
        vecs[2]  = '{8'h41, 8'h00, 8'h00, 1, 8'h15, 1'b0};
        vecs[3]  = '{8'h57, 8'h07, 8'h11, 3, 8'h15, 1'b0};
        vecs[4]  = '{8'h52, 8'h07, 8'h00, 2, 8'h15, 1'b0};
        vecs[5]  = '{8'h57, 8'h05, 8'h3C, 3, 8'h06, 1'b1};
        vecs[6]  = '{8'h52, 8'h05, 8'h00, 2, 8'h3C, 1'b0};
        vecs[7]  = '{8'h52, 8'h06, 8'h00, 2, 8'h15, 1'b0};
        vecs[8]  = '{8'h57, 8'h0A, 8'h77, 3, 8'h15, 1'b0};
        vecs[9]  = '{8'h52, 8'h02, 8'h00, 2, 8'hA5, 1'b0};
        vecs[10] = '{8'h57, 8'h00, 8'hFF, 3, 8'h06, 1'b1};
        vecs[11] = '{8'h52, 8'h00, 8'h00, 2, 8'hFF, 1'b0};
        vecs[12] = '{8'h52, 8'h01, 8'h00, 2, 8'h00, 1'b0};
        vecs[13] = '{8'h77, 8'h00, 8'h00, 1, 8'h15, 1'b0};
        for (int k = 0; k < NUM_REGS; k++) exp_regs[k] = 8'h00;

        // Reset state
        tick();
        tick();
        @(negedge clk_in);
        check("rst_busy", 64'(busy_out), 64'd0);
        check("rst_tx_dv", 64'(tx_dv_out), 64'd0);
        check("rst_tx_data", 64'(tx_data_out), 64'd0);
        check("rst_wr", 64'({wr_strobe_out, wr_addr_out, overrun_out}), 64'd0);
        check_regs("rst_regs");
        rst_in_n = 1'b1;
        tick();

        // Write latency: regs update one cycle after the strobe, tx two cycles after the byte
        reply_q.push_back(8'h06);
        wr_q.push_back(3'd3);
        exp_regs[3] = 8'h5A;
        send_byte(8'h57);
        send_byte(8'h03);
        rx_data_in = 8'h5A;
        rx_dv_in   = 1'b1;
        @(negedge clk_in);
        check("lat_busy", 64'(busy_out), 64'd1);
        tick();
        rx_dv_in = 1'b0;
        @(negedge clk_in);
        check("lat_exec_strobe", 64'(wr_strobe_out), 64'd1);
        check("lat_exec_addr", 64'(wr_addr_out), 64'd3);
        check("lat_exec_reg_old", 64'(regs_out[31:24]), 64'h00);
        check("lat_exec_no_tx", 64'(tx_dv_out), 64'd0);
        @(negedge clk_in);
        check("lat_send_reg_new", 64'(regs_out[31:24]), 64'h5A);
        check("lat_send_tx_dv", 64'(tx_dv_out), 64'd1);
        check("lat_send_strobe_off", 64'(wr_strobe_out), 64'd0);
        wait_idle("lat_done");
        check("lat_wr_addr_hold", 64'(wr_addr_out), 64'd3);

        // Table of frames
        for (int i = 0; i < NV; i++) begin
            reply_q.push_back(vecs[i].reply);
            if (vecs[i].wr) begin
                wr_q.push_back(vecs[i].b1[ADDR_W-1:0]);
                exp_regs[vecs[i].b1[ADDR_W-1:0]] = vecs[i].b2;
            end
            send_byte(vecs[i].b0);
            if (vecs[i].nb > 1) send_byte(vecs[i].b1);
            if (vecs[i].nb > 2) send_byte(vecs[i].b2);
            wait_idle("frame_done");
            check_regs("frame_regs");
        end

        // Overrun during WAIT_DONE
        reply_q.push_back(exp_regs[0]);
        base = tx_seen;
        send_byte(8'h52);
        send_byte(8'h00);
        wait_tx_start(base);
        ovr_base = ovr_cnt;
        send_byte(8'h33);
        check("ovr_pulse", 64'(ovr_cnt - ovr_base), 64'd1);
        check("ovr_fsm_busy", 64'(busy_out), 64'd1);
        wait_idle("ovr_done");
        check("ovr_single", 64'(ovr_cnt - ovr_base), 64'd1);
        reply_q.push_back(exp_regs[5]);
        send_byte(8'h52);
        send_byte(8'h05);
        wait_idle("ovr_next_frame");

        // tx_done_in and rx_dv_in together in WAIT_DONE
        manual_tx = 1'b1;
        reply_q.push_back(exp_regs[1]);
        base = tx_seen;
        send_byte(8'h52);
        send_byte(8'h01);
        wait_tx_start(base);
        tick();
        tick();
        ovr_base   = ovr_cnt;
        man_done   = 1'b1;
        rx_data_in = 8'h44;
        rx_dv_in   = 1'b1;
        @(negedge clk_in);
        check("done_rx_overrun", 64'(overrun_out), 64'd1);
        tick();
        man_done = 1'b0;
        rx_dv_in = 1'b0;
        @(negedge clk_in);
        check("done_rx_idle", 64'(busy_out), 64'd0);
        check("done_rx_ovr_count", 64'(ovr_cnt - ovr_base), 64'd1);
        manual_tx = 1'b0;
        tick();
        reply_q.push_back(exp_regs[2]);
        send_byte(8'h52);
        send_byte(8'h02);
        wait_idle("done_rx_next_frame");

        // tx busy holds the reply in SEND
        hold_busy = 1'b1;
        reply_q.push_back(exp_regs[5]);
        base = tx_seen;
        send_byte(8'h52);
        send_byte(8'h05);
        repeat (10) tick();
        check("busy_no_tx", 64'(tx_seen - base), 64'd0);
        check("busy_in_send", 64'(busy_out), 64'd1);
        hold_busy = 1'b0;
        wait_idle("busy_release");
        check("busy_one_tx", 64'(tx_seen - base), 64'd1);

        // Reset mid-frame
        send_byte(8'h57);
        send_byte(8'h01);
        pulse_reset();
        @(negedge clk_in);
        check("midrst_busy", 64'(busy_out), 64'd0);
        check_regs("midrst_regs");
        tick();
        reply_q.push_back(8'h00);
        send_byte(8'h52);
        send_byte(8'h01);
        wait_idle("midrst_read");

        // Inter-byte timeout
        base = tx_seen;
        send_byte(8'h57);
        repeat (TIMEOUT_CLKS + 5) tick();
`ifdef UART_CMD_TIMEOUT_EN
        check("timeout_idle", 64'(busy_out), 64'd0);
`else
        check("no_timeout_busy", 64'(busy_out), 64'd1);
        pulse_reset();
`endif
        check("timeout_no_tx", 64'(tx_seen - base), 64'd0);
        reply_q.push_back(exp_regs[0]);
        send_byte(8'h52);
        send_byte(8'h00);
        wait_idle("timeout_next_frame");

        check("reply_queue_empty", 64'(reply_q.size()), 64'd0);
        check("wr_queue_empty", 64'(wr_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
